// File: rtl/keystream_sched_if.sv
// keystream_sched_if: key byte input stream and keystream byte output stream (valid/ready)
interface keystream_sched_if;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_byte;
  logic       ks_valid;
  logic       ks_ready;
  logic [7:0] ks_byte;
  modport master(output key_valid, key_byte, ks_ready, input key_ready, ks_valid, ks_byte);
  modport slave(input key_valid, key_byte, ks_ready, output key_ready, ks_valid, ks_byte);
endinterface

// File: rtl/keystream_sched.sv
// keystream_sched: key load, warm-up rounds, then valid/ready keystream from a 4-tap byte shift register mixer; ports clk, rst_n, start, stop, bus (key in, ks out), busy, init_done
module keystream_sched #(
  parameter int STATE_BYTES = 16,
  parameter int INIT_ROUNDS = 32,
  parameter int TAP1 = 5,
  parameter int TAP2 = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  keystream_sched_if.slave bus,
  output logic             busy,
  output logic             init_done
);
  localparam int LW = $clog2(STATE_BYTES);
  localparam int RW = $clog2(INIT_ROUNDS + 1);
  typedef enum logic [1:0] {IDLE, LOAD, INIT, RUN} state_t;
  state_t        state, state_nx;
  logic [7:0]    st [STATE_BYTES];
  logic [7:0]    st_sh [STATE_BYTES];
  logic [LW-1:0] ld_cnt;
  logic [RW-1:0] rnd_cnt;
  logic [7:0]    x, m, fb;
  logic          key_fire, ks_adv, shift;
  always_comb begin
    x        = st[TAP1] ^ st[TAP2];
    m        = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00) ^ st[0] ^ st[TAP2] ^ st[STATE_BYTES-1];
    fb       = m ^ st[0] ^ (state == INIT ? 8'(rnd_cnt) : 8'h00);
    key_fire = state == LOAD && bus.key_valid && !stop;
    ks_adv   = state == RUN && !stop && (!bus.ks_valid || bus.ks_ready);
    shift    = (state == INIT && !stop) || ks_adv;
  end
  always_comb begin
    for (int i = 0; i < STATE_BYTES - 1; i++) st_sh[i] = st[i + 1];
    st_sh[STATE_BYTES-1] = fb;
  end
  always_comb begin
    bus.key_ready = state == LOAD;
    busy          = state != IDLE;
    state_nx      = stop ? IDLE :
                    state == IDLE ? (start ? LOAD : IDLE) :
                    state == LOAD ? (key_fire && ld_cnt == LW'(STATE_BYTES - 1) ? INIT : LOAD) :
                    state == INIT ? (rnd_cnt == RW'(INIT_ROUNDS - 1) ? RUN : INIT) : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ld_cnt       <= '0;
      rnd_cnt      <= '0;
      init_done    <= 1'b0;
      bus.ks_valid <= 1'b0;
      bus.ks_byte  <= 8'h00;
      for (int i = 0; i < STATE_BYTES; i++) st[i] <= 8'h00;
    end else begin
      ld_cnt    <= state == LOAD && state_nx == LOAD ? ld_cnt + LW'(key_fire) : '0;
      rnd_cnt   <= state == INIT && state_nx == INIT ? rnd_cnt + RW'(1) : '0;
      init_done <= state == INIT && state_nx == RUN;
      if (stop) bus.ks_valid <= 1'b0;
      else if (ks_adv) begin
        bus.ks_valid <= 1'b1;
        bus.ks_byte  <= m;
      end
      for (int i = 0; i < STATE_BYTES; i++)
        if (key_fire && ld_cnt == LW'(i)) st[i] <= bus.key_byte;
        else if (shift) st[i] <= st_sh[i];
    end
endmodule

// File: tb/tb_keystream_sched.sv
// tb_keystream_sched: table-driven sessions against a queue-based keystream model plus stop/reset corner sequences
module tb_keystream_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic busy, init_done;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [7:0] kmem [16];
  logic [7:0] gold [64];
  keystream_sched_if bus();
  keystream_sched dut(.clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .bus(bus), .busy(busy), .init_done(init_done));
  always #5 clk = ~clk;
  typedef struct {
    bit zero_key;
    int gap;
    int rdy_mode;
    int nbytes;
    bit start_mid;
    int exp_lat;
  } vec_t;
  vec_t vecs [5];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] s_mix(input logic [7:0] a0, a1, a2, a3);
    logic [7:0] t;
    t = a1 ^ a2;
    t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    return t ^ a0 ^ a2 ^ a3;
  endfunction
  task automatic gen_gold(input int n);
    logic [7:0] q [$];
    logic [7:0] mm;
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(kmem[i]);
    for (int r = 0; r < 32; r++) begin
      mm = s_mix(q[0], q[5], q[10], q[15]);
      q.push_back(mm ^ q[0] ^ 8'(r));
      void'(q.pop_front());
    end
    for (int k = 0; k < n; k++) begin
      mm = s_mix(q[0], q[5], q[10], q[15]);
      gold[k] = mm;
      q.push_back(mm ^ q[0]);
      void'(q.pop_front());
    end
  endtask
  function automatic logic ready_at(input int mode, input int k);
    if (mode == 0 || k < 0) return 1'b1;
    if (k < 8) return k % 2 == 0;
    return k >= 13;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic run_session(input int id, input vec_t v);
    int c, beats, got, bubbles, inits, init_cyc, lat;
    logic was_stall;
    logic [7:0] held_b;
    for (int i = 0; i < 16; i++) kmem[i] = v.zero_key ? 8'h00 : 8'(i);
    gen_gold(v.nbytes);
    c = 0; beats = 0; got = 0; bubbles = 0; inits = 0; init_cyc = -1; lat = -1;
    was_stall = 1'b0; held_b = 8'h00;
    while (got < v.nbytes && c < 400) begin
      start = c == 0 || (v.start_mid && (c == 5 || c == v.exp_lat + 2));
      bus.key_valid = c > 0 && c % v.gap == 0;
      bus.key_byte = beats < 16 ? kmem[beats] : 8'ha5;
      bus.ks_ready = ready_at(v.rdy_mode, c - v.exp_lat);
      @(negedge clk);
      if (was_stall) begin
        chk($sformatf("v%0d_stall_valid_c%0d", id, c), 32'(bus.ks_valid), 32'd1);
        chk($sformatf("v%0d_stall_byte_c%0d", id, c), 32'(bus.ks_byte), 32'(held_b));
      end
      if (bus.ks_valid && lat < 0) lat = c;
      if (lat >= 0 && !bus.ks_valid) bubbles++;
      if (init_done) begin
        inits++;
        init_cyc = c;
      end
      if (bus.key_valid && bus.key_ready) beats++;
      if (bus.ks_valid && bus.ks_ready) begin
        chk($sformatf("v%0d_byte%0d", id, got), 32'(bus.ks_byte), 32'(gold[got]));
        got++;
      end
      was_stall = bus.ks_valid && !bus.ks_ready;
      held_b = bus.ks_byte;
      cyc();
      c++;
    end
    start = 1'b0;
    bus.key_valid = 1'b0;
    chk($sformatf("v%0d_bytes_out", id), 32'(got), 32'(v.nbytes));
    chk($sformatf("v%0d_latency", id), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_key_beats", id), 32'(beats), 32'd16);
    chk($sformatf("v%0d_init_done_cnt", id), 32'(inits), 32'd1);
    chk($sformatf("v%0d_init_done_cyc", id), 32'(init_cyc), 32'(v.exp_lat - 1));
    if (v.rdy_mode == 0) chk($sformatf("v%0d_bubbles", id), 32'(bubbles), 32'd0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk($sformatf("v%0d_stop_busy", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d_stop_ks_valid", id), 32'(bus.ks_valid), 32'd0);
    chk($sformatf("v%0d_stop_key_ready", id), 32'(bus.key_ready), 32'd0);
  endtask
  task automatic prime(input int n);
    for (int c = 0; c < n; c++) begin
      start = c == 0;
      bus.key_valid = c >= 1;
      bus.key_byte = c >= 1 && c <= 16 ? 8'(c - 1) : 8'ha5;
      bus.ks_ready = 1'b0;
      cyc();
    end
    start = 1'b0;
    bus.key_valid = 1'b0;
  endtask
  initial begin
    int inits, valids;
    vecs[0] = '{1'b1, 1, 0, 20, 1'b0, 50};
    vecs[1] = '{1'b0, 1, 0, 64, 1'b0, 50};
    vecs[2] = '{1'b0, 1, 1, 20, 1'b0, 50};
    vecs[3] = '{1'b0, 3, 0, 16, 1'b1, 82};
    vecs[4] = '{1'b0, 2, 1, 24, 1'b1, 66};
    bus.key_valid = 1'b0;
    bus.key_byte = 8'h00;
    bus.ks_ready = 1'b0;
    cyc();
    cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_key_ready", 32'(bus.key_ready), 32'd0);
    chk("rst_ks_valid", 32'(bus.ks_valid), 32'd0);
    chk("rst_ks_byte", 32'(bus.ks_byte), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    rst_n = 1'b1;
    cyc();
    start = 1'b1;
    stop = 1'b1;
    bus.key_valid = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_idle_busy", 32'(busy), 32'd0);
    chk("idle_key_ready", 32'(bus.key_ready), 32'd0);
    bus.key_valid = 1'b0;
    for (int i = 0; i < 5; i++) run_session(i, vecs[i]);
    prime(27);
    chk("t5_busy_before_stop", 32'(busy), 32'd1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("t5_busy_after_stop", 32'(busy), 32'd0);
    inits = 0;
    valids = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      inits += int'(init_done);
      valids += int'(bus.ks_valid);
      cyc();
    end
    chk("t5_no_init_done", 32'(inits), 32'd0);
    chk("t5_no_ks_valid", 32'(valids), 32'd0);
    run_session(5, vecs[1]);
    prime(53);
    chk("t6_valid_before_rst", 32'(bus.ks_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_ks_valid", 32'(bus.ks_valid), 32'd0);
    chk("t6_async_ks_byte", 32'(bus.ks_byte), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_key_ready", 32'(bus.key_ready), 32'd0);
    chk("t6_async_init_done", 32'(init_done), 32'd0);
    cyc();
    rst_n = 1'b1;
    bus.ks_ready = 1'b1;
    bus.key_valid = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    bus.key_valid = 1'b0;
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_ks_valid", 32'(bus.ks_valid), 32'd0);
    run_session(6, vecs[1]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
